// File: rtl/ram_mp_clr.sv
// Multi-port register-array RAM with a sequential clear engine.
// NRD combinational read ports and NWR synchronous write ports. Writes that
// hit the same index resolve to the highest-numbered port. Reset and clear_in
// start a clear engine that writes INITVALUE into one entry per cycle. While
// it runs, the array is reported busy and reads return INITVALUE.
// Optional feature: define RAM_MP_BYPASS_EN to forward same-cycle write data
// to matching reads. Without it, reads see the pre-write contents.
module ram_mp_clr #(
  parameter int unsigned          DATAWIDTH = 64,
  parameter int unsigned          INDEXSIZE = 256,
  parameter int unsigned          LOGINDEX  = 8,
  parameter logic [DATAWIDTH-1:0] INITVALUE = '0,
  parameter int unsigned          NRD       = 2,
  parameter int unsigned          NWR       = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_in,
  input  logic [NWR-1:0]           we_in,
  input  logic [NWR*DATAWIDTH-1:0] wdata_in,
  input  logic [NWR*LOGINDEX-1:0]  windex_in,
  input  logic [NRD*LOGINDEX-1:0]  rindex_in,
  output logic [NRD*DATAWIDTH-1:0] rdata_out,
  output logic                     busy_out,
  output logic                     wcollide_out
);

  // Bits needed to address the implemented entries. In-range indices are
  // checked first, so the upper index bits can be dropped.
  localparam int unsigned AW = $clog2(INDEXSIZE);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                 state_q;
  logic [LOGINDEX-1:0]    clr_idx_q;
  logic [DATAWIDTH-1:0]   ram_q [INDEXSIZE];

  logic                   wr_ok;
  logic [NWR-1:0]         wr_act;

  assign busy_out = (state_q == StClear);

  // User writes are taken only in idle, with no clear request and no reset.
  assign wr_ok = (state_q == StIdle) && !clear_in && !reset;

  // Per-port write qualification: enabled, accepted and in range.
  always_comb begin
    wr_act = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      wr_act[k] = wr_ok && we_in[k] &&
                  (32'(windex_in[k*LOGINDEX +: LOGINDEX]) < INDEXSIZE);
    end
  end

  // Clear-engine FSM: reset or clear_in restarts the sweep from entry 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clear_in) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
          end
        end
        StClear: begin
          if (clear_in) begin
            clr_idx_q <= '0;
          end else if (32'(clr_idx_q) == INDEXSIZE - 1) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + LOGINDEX'(1);
          end
        end
        default: begin
          state_q   <= StClear;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  // Array update: clear-engine writes while sweeping, otherwise user writes
  // in port order so the highest-numbered port wins on a collision.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == StClear) && !clear_in) begin
      ram_q[clr_idx_q[AW-1:0]] <= INITVALUE;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_act[k]) begin
          ram_q[windex_in[k*LOGINDEX +: AW]] <= wdata_in[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // Combinational read ports; busy or out-of-range reads return INITVALUE.
  always_comb begin
    rdata_out = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      logic [LOGINDEX-1:0]  ridx;
      logic [DATAWIDTH-1:0] rd;
      ridx = rindex_in[j*LOGINDEX +: LOGINDEX];
      rd   = INITVALUE;
      if (!busy_out && (32'(ridx) < INDEXSIZE)) begin
        rd = ram_q[ridx[AW-1:0]];
      end
`ifdef RAM_MP_BYPASS_EN
      // Forward same-cycle accepted write data; later ports override earlier.
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_act[k] && (windex_in[k*LOGINDEX +: LOGINDEX] == ridx)) begin
          rd = wdata_in[k*DATAWIDTH +: DATAWIDTH];
        end
      end
`endif
      rdata_out[j*DATAWIDTH +: DATAWIDTH] = rd;
    end
  end

  // Collision flag: two or more enabled ports share an index while idle.
  always_comb begin
    wcollide_out = 1'b0;
    if (state_q == StIdle) begin
      for (int unsigned a = 0; a < NWR; a++) begin
        for (int unsigned b = a + 1; b < NWR; b++) begin
          if (we_in[a] && we_in[b] &&
              (windex_in[a*LOGINDEX +: LOGINDEX] == windex_in[b*LOGINDEX +: LOGINDEX])) begin
            wcollide_out = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_mp_clr.sv
// Self-checking bench for ram_mp_clr: directed scenarios with literal
// expectations plus randomized traffic checked against an array model.
module tb_ram_mp_clr;

  localparam int unsigned DW  = 16;
  localparam int unsigned N   = 16;
  localparam int unsigned LI  = 5;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 3;
  localparam logic [DW-1:0] INIT = 16'hBEEF;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_in = 1'b0;
  logic [NWR-1:0]    we_in = '0;
  logic [NWR*DW-1:0] wdata_in;
  logic [NWR*LI-1:0] windex_in;
  logic [NRD*LI-1:0] rindex_in;
  logic [NRD*DW-1:0] rdata_out;
  logic              busy_out;
  logic              wcollide_out;

  logic [DW-1:0] wd [NWR];
  logic [LI-1:0] wi [NWR];
  logic [LI-1:0] ri [NRD];

  int  checks = 0;
  int  errors = 0;
  bit  check_en = 1'b0;

  // Reference model: remaining clear cycles and the visible array contents.
  int            remaining = 0;
  logic [DW-1:0] mem [N];

  ram_mp_clr #(
    .DATAWIDTH (DW),
    .INDEXSIZE (N),
    .LOGINDEX  (LI),
    .INITVALUE (INIT),
    .NRD       (NRD),
    .NWR       (NWR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear_in     (clear_in),
    .we_in        (we_in),
    .wdata_in     (wdata_in),
    .windex_in    (windex_in),
    .rindex_in    (rindex_in),
    .rdata_out    (rdata_out),
    .busy_out     (busy_out),
    .wcollide_out (wcollide_out)
  );

  always #5 clock = ~clock;

  always_comb begin
    wdata_in  = '0;
    windex_in = '0;
    rindex_in = '0;
    for (int k = 0; k < NWR; k++) begin
      wdata_in[k*DW +: DW]  = wd[k];
      windex_in[k*LI +: LI] = wi[k];
    end
    for (int j = 0; j < NRD; j++) rindex_in[j*LI +: LI] = ri[j];
  end

  function automatic logic [DW-1:0] rd(input int j);
    return rdata_out[j*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts busy cycles starting with the current one; returns just after a posedge.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy_out) begin
        @(posedge clock);
        #1;
        return;
      end
      cnt++;
      @(posedge clock);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy still high after %0d cycles, expected release", cnt);
  endtask

  // Model update at each active edge, from the specification's rules.
  always @(posedge clock) begin
    if (reset) begin
      remaining = N;
      for (int i = 0; i < N; i++) mem[i] = INIT;
    end else if (remaining > 0) begin
      remaining = clear_in ? N : remaining - 1;
    end else if (clear_in) begin
      remaining = N;
      for (int i = 0; i < N; i++) mem[i] = INIT;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we_in[k] && (wi[k] < N)) mem[wi[k]] = wd[k];
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    bit            col;
    if (check_en) begin
      chk("busy", DW'(busy_out), DW'(remaining > 0));
      for (int j = 0; j < NRD; j++) begin
        e = INIT;
        if ((remaining == 0) && (ri[j] < N)) begin
          e = mem[ri[j]];
`ifdef RAM_MP_BYPASS_EN
          for (int k = 0; k < NWR; k++) begin
            if (we_in[k] && !clear_in && !reset && (wi[k] == ri[j])) e = wd[k];
          end
`endif
        end
        chk($sformatf("rdata%0d idx%0d", j, ri[j]), rd(j), e);
      end
      col = 1'b0;
      if (remaining == 0) begin
        for (int a = 0; a < NWR; a++) begin
          for (int b = a + 1; b < NWR; b++) begin
            if (we_in[a] && we_in[b] && (wi[a] == wi[b])) col = 1'b1;
          end
        end
      end
      chk("wcollide", DW'(wcollide_out), DW'(col));
    end
  end

  initial begin
    int cnt;
    for (int k = 0; k < NWR; k++) begin
      wd[k] = '0;
      wi[k] = '0;
    end
    for (int j = 0; j < NRD; j++) ri[j] = '0;

    // Reset pulse, then busy for exactly N cycles and all entries INITVALUE.
    tick();
    check_en = 1'b1;
    reset = 1'b0;
    wait_idle(cnt);
    chk("t1_busy_len", cnt[DW-1:0], DW'(16));
    for (int i = 0; i < N; i += 2) begin
      ri[0] = LI'(i);
      ri[1] = LI'(i + 1);
      @(negedge clock);
      chk("t1_init_p0", rd(0), 16'hBEEF);
      chk("t1_init_p1", rd(1), 16'hBEEF);
      tick();
    end

    // Same-index collision: highest port wins.
    wi[0] = 5; wd[0] = 16'h00A5;
    wi[1] = 5; wd[1] = 16'h005A;
    we_in = 3'b011;
    @(negedge clock);
    chk("t2_wcollide", DW'(wcollide_out), DW'(1));
    tick();
    we_in = '0;
    ri[0] = 5;
    @(negedge clock);
    chk("t2_read_idx5", rd(0), 16'h005A);
    tick();

    // Write and read idx9 in the same cycle.
    wi[1] = 9; wd[1] = 16'h1234;
    we_in = 3'b010;
    ri[1] = 9;
    @(negedge clock);
`ifdef RAM_MP_BYPASS_EN
    chk("t5_same_cycle", rd(1), 16'h1234);
`else
    chk("t5_same_cycle", rd(1), 16'hBEEF);
`endif
    tick();
    we_in = '0;
    @(negedge clock);
    chk("t5_next_cycle", rd(1), 16'h1234);
    tick();

    // Out-of-range write is dropped and does not alias onto idx4.
    wi[2] = 4; wd[2] = 16'h4444;
    we_in = 3'b100;
    tick();
    wi[0] = 20; wd[0] = 16'h1111;
    we_in = 3'b001;
    tick();
    we_in = '0;
    ri[0] = 20;
    ri[1] = 4;
    @(negedge clock);
    chk("oor_read", rd(0), 16'hBEEF);
    chk("oor_alias", rd(1), 16'h4444);
    tick();

    // clear_in drops a same-cycle write; writes during busy are dropped too.
    wi[0] = 3; wd[0] = 16'h0077;
    we_in = 3'b001;
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      wi[k] = 2;
      wd[k] = 16'h00FF;
    end
    we_in = 3'b111;
    ri[0] = 7;
    ri[1] = 2;
    @(negedge clock);
    chk("t3_busy", DW'(busy_out), DW'(1));
    chk("t6_busy_read", rd(0), 16'hBEEF);
    chk("t6_busy_wcollide", DW'(wcollide_out), DW'(0));
    tick();
    we_in = '0;
    wait_idle(cnt);
    chk("t3_busy_len", DW'(cnt + 1), DW'(16));
    ri[0] = 3;
    ri[1] = 2;
    @(negedge clock);
    chk("t3_idx3", rd(0), 16'hBEEF);
    chk("t6_idx2", rd(1), 16'hBEEF);
    tick();

    // clear_in mid-clear restarts the full sweep.
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    repeat (8) tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    wait_idle(cnt);
    chk("t4_restart_len", cnt[DW-1:0], DW'(16));

    // Reset mid-clear restarts the full sweep from reset release.
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(cnt);
    chk("t4_reset_len", cnt[DW-1:0], DW'(16));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      clear_in = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NWR; k++) begin
        we_in[k] = ($urandom_range(0, 2) == 0);
        wi[k]    = LI'($urandom_range(0, N + 3));
        wd[k]    = DW'($urandom);
      end
      for (int j = 0; j < NRD; j++) ri[j] = LI'($urandom_range(0, N + 3));
      tick();
    end
    reset    = 1'b0;
    clear_in = 1'b0;
    we_in    = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
